// File: rtl/matrix_inv_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// matrix_inv_seq
//   Sequential exact-integer inverter for an NxN signed matrix. The augmented
//   matrix [A|I] sits in an N x 2N register array. Fraction-free (Bareiss)
//   Gauss-Jordan elimination runs on it, swapping rows when a pivot is zero.
//   The result leaves as adj'(A), row-major, together with det_o, so that
//   A^-1 = out_data / det_o. A singular matrix yields det_o=0, all-zero
//   beats and singular=1.
//
//   Parameters: N (2..8) matrix dimension, W signed element width.
//
//   Ports:
//     clk, rst            rising-edge clock, asynchronous active-high reset
//     in_valid/in_ready   input handshake (in_ready high only in LOAD)
//     in_data   [W-1:0]   A elements, row-major
//     out_valid/out_ready output handshake
//     out_data  [W-1:0]   adj' elements, row-major
//     out_last            high on beat N*N
//     det_o     [W-1:0]   scaling scalar, stable while out_valid
//     singular            A found singular, held through OUT
//     busy                high in every state except LOAD
//     ovf                 (only with MATINV_OVF_CHECK_EN) sticky flag, set when
//                         an update result does not fit W signed bits
//
//   Build option: define MATINV_OVF_CHECK_EN to add the ovf port and its check.
// -----------------------------------------------------------------------------
module matrix_inv_seq #(
    parameter int N = 5,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic [W-1:0] det_o,
    output logic         singular,
    output logic         busy
`ifdef MATINV_OVF_CHECK_EN
    ,
    output logic         ovf
`endif
);

    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(2 * N);
    localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(2 * N - 1);
    localparam logic [CW-1:0] HALF     = CW'(N);

    typedef enum logic [2:0] {
        S_LOAD, S_SEARCH, S_SWAP, S_ELIM_F, S_ELIM_U, S_OUT
    } state_t;

    state_t state_q, state_d;

    logic signed [W-1:0] m [N][2*N];
    logic [RW-1:0] k, r, i, row_cnt, col_cnt;
    logic [CW-1:0] j;
    logic signed [W-1:0] p, f, prev;
    logic parity;

    logic cnt_last, pivot_nz, elim_done;
    logic [RW-1:0] first_i, next_i;
    logic signed [W-1:0] pivot_cand, upd, rd_out, rd_det;
    logic signed [2*W-1:0] num;
`ifdef MATINV_OVF_CHECK_EN
    logic signed [2*W-1:0] quo;
    logic upd_ovf;
`endif

    // ---------------- datapath helpers ----------------
    // NOTE: every always_comb output gets a default before any branch;
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        int ni;
        ni         = int'(i) + 1;
        if (ni == int'(k)) ni = ni + 1;      // the pivot row is skipped
        elim_done  = (ni >= N);
        next_i     = RW'(ni);
        first_i    = (k == '0) ? RW'(1) : '0;

        cnt_last   = (row_cnt == LAST_ROW) && (col_cnt == LAST_ROW);
        pivot_cand = m[r][CW'(k)];
        pivot_nz   = (pivot_cand != '0);

        // Bareiss update: (p*M[i][j] - f*M[k][j]) / prev, exact by construction.
        num = (2*W)'(p) * (2*W)'(m[i][j]) - (2*W)'(f) * (2*W)'(m[k][j]);
`ifdef MATINV_OVF_CHECK_EN
        quo     = num / (2*W)'(prev);
        upd     = quo[W-1:0];
        upd_ovf = (quo[2*W-1:W-1] != '0) && (quo[2*W-1:W-1] != '1);
`else
        upd = W'(num / (2*W)'(prev));
`endif

        rd_out = m[row_cnt][HALF + CW'(col_cnt)];
        rd_det = m[0][0];
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_LOAD;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid && cnt_last) state_d = S_SEARCH;
            end
            S_SEARCH: begin
                if (pivot_nz)              state_d = (r == k) ? S_ELIM_F : S_SWAP;
                else if (r == LAST_ROW)    state_d = S_OUT;
            end
            S_SWAP:   if (j == LAST_COL) state_d = S_ELIM_F;
            S_ELIM_F: state_d = S_ELIM_U;
            S_ELIM_U: begin
                if (j == LAST_COL) begin
                    if (!elim_done)          state_d = S_ELIM_F;
                    else if (k == LAST_ROW)  state_d = S_OUT;
                    else                     state_d = S_SEARCH;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready && cnt_last) state_d = S_LOAD;
            end
            default: state_d = S_LOAD;
        endcase
    end

    // Outputs are forced to zero outside OUT and for a singular matrix; an odd
    // number of row swaps flips the sign of both det and the adjugate.
    assign out_last = out_valid && cnt_last;
    assign out_data = (!out_valid || singular) ? '0 : (parity ? -rd_out : rd_out);
    assign det_o    = (!out_valid || singular) ? '0 : (parity ? -rd_det : rd_det);

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the matrix is a flop array, not a RAM, so it can be cleared
            // here; a reset mid-computation leaves no stale data behind.
            for (int a = 0; a < N; a++)
                for (int b = 0; b < 2 * N; b++)
                    m[a][b] <= '0;
            k        <= '0;
            r        <= '0;
            i        <= '0;
            j        <= '0;
            row_cnt  <= '0;
            col_cnt  <= '0;
            p        <= '0;
            f        <= '0;
            prev     <= W'(1);
            parity   <= 1'b0;
            singular <= 1'b0;
`ifdef MATINV_OVF_CHECK_EN
            ovf      <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_LOAD: if (in_valid) begin
                    m[row_cnt][CW'(col_cnt)]        <= in_data;
                    m[row_cnt][HALF + CW'(col_cnt)] <= (row_cnt == col_cnt) ? W'(1) : '0;
                    if (col_cnt == LAST_ROW) begin
                        col_cnt <= '0;
                        row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + RW'(1);
                    end else begin
                        col_cnt <= col_cnt + RW'(1);
                    end
                    if (cnt_last) begin
                        k      <= '0;
                        r      <= '0;
                        prev   <= W'(1);
                        parity <= 1'b0;
                    end
                end
                S_SEARCH: begin
                    if (pivot_nz) begin
                        p <= pivot_cand;
                        i <= first_i;
                        j <= '0;
                    end else if (r == LAST_ROW) begin
                        singular <= 1'b1;
                    end else begin
                        r <= r + RW'(1);
                    end
                end
                S_SWAP: begin
                    // NOTE: non-blocking assignments read both old values
                    // before either is written, so the exchange needs no temp.
                    m[k][j] <= m[r][j];
                    m[r][j] <= m[k][j];
                    if (j == LAST_COL) begin
                        parity <= ~parity;
                        j      <= '0;
                    end else begin
                        j <= j + CW'(1);
                    end
                end
                S_ELIM_F: begin
                    // f is latched so column k of row i can be overwritten
                    // during the sweep without disturbing later columns.
                    f <= m[i][CW'(k)];
                    j <= '0;
                end
                S_ELIM_U: begin
                    m[i][j] <= upd;
`ifdef MATINV_OVF_CHECK_EN
                    if (upd_ovf) ovf <= 1'b1;
`endif
                    if (j == LAST_COL) begin
                        j <= '0;
                        if (elim_done) begin
                            prev <= p;
                            if (k != LAST_ROW) begin
                                k <= k + RW'(1);
                                r <= k + RW'(1);
                            end
                        end else begin
                            i <= next_i;
                        end
                    end else begin
                        j <= j + CW'(1);
                    end
                end
                S_OUT: if (out_ready) begin
                    if (col_cnt == LAST_ROW) begin
                        col_cnt <= '0;
                        row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + RW'(1);
                    end else begin
                        col_cnt <= col_cnt + RW'(1);
                    end
                    if (cnt_last) begin
                        singular <= 1'b0;
`ifdef MATINV_OVF_CHECK_EN
                        ovf      <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_inv_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_matrix_inv_seq
//   Three instances (N=2, N=3, N=5) driven with directed matrices. The model
//   computes det(A) and adj(A) from cofactors (Leibniz determinant), which is
//   what the block must produce; a single negedge process compares every
//   valid output beat of every instance against the expected queue.
// -----------------------------------------------------------------------------
module tb_matrix_inv_seq;

    localparam int W  = 32;
    localparam int NI = 3;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [31:0] det;
        logic        sing;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid  [NI];
    logic           in_ready  [NI];
    logic [W-1:0]   in_data   [NI];
    logic           out_valid [NI];
    logic           out_ready [NI];
    logic [W-1:0]   out_data  [NI];
    logic           out_last  [NI];
    logic [W-1:0]   det_o     [NI];
    logic           singular  [NI];
    logic           busy      [NI];
`ifdef MATINV_OVF_CHECK_EN
    logic           ovf       [NI];
`endif

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t exp_q [NI][$];
    int   mat [64];

    always #5 clk = ~clk;

    matrix_inv_seq #(.N(2), .W(W)) u_n2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_last(out_last[0]), .det_o(det_o[0]), .singular(singular[0]), .busy(busy[0])
`ifdef MATINV_OVF_CHECK_EN
        , .ovf(ovf[0])
`endif
    );

    matrix_inv_seq #(.N(3), .W(W)) u_n3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_last(out_last[1]), .det_o(det_o[1]), .singular(singular[1]), .busy(busy[1])
`ifdef MATINV_OVF_CHECK_EN
        , .ovf(ovf[1])
`endif
    );

    matrix_inv_seq #(.N(5), .W(W)) u_n5 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
        .out_last(out_last[2]), .det_o(det_o[2]), .singular(singular[2]), .busy(busy[2])
`ifdef MATINV_OVF_CHECK_EN
        , .ovf(ovf[2])
`endif
    );

    task automatic check(input string name, input longint act, input longint req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, req);
    endtask

    // Leibniz determinant: sum over all permutations of signed products.
    function automatic longint det_n(input longint a[8][8], input int n);
        longint total;
        int     tuples;
        int     dig [8];
        total  = 0;
        tuples = 1;
        for (int c = 0; c < n; c++) tuples *= n;
        for (int t = 0; t < tuples; t++) begin
            int     v;
            int     inv;
            bit     ok;
            longint prod;
            v = t; inv = 0; ok = 1'b1; prod = 1;
            for (int c = 0; c < n; c++) begin
                dig[c] = v % n;
                v      = v / n;
            end
            for (int c1 = 0; c1 < n; c1++)
                for (int c2 = c1 + 1; c2 < n; c2++) begin
                    if (dig[c1] == dig[c2]) ok = 1'b0;
                    if (dig[c1] > dig[c2]) inv++;
                end
            if (ok) begin
                for (int c = 0; c < n; c++) prod *= a[c][dig[c]];
                total += (inv % 2 == 1) ? -prod : prod;
            end
        end
        return total;
    endfunction

    // Expected stream: adj(A) row-major with det(A); all zero when singular.
    task automatic build_expect(input int d, input int n);
        longint a   [8][8];
        longint mnr [8][8];
        longint det;
        longint cof;
        exp_t   e;
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++) begin
                a[x][y]   = 0;
                mnr[x][y] = 0;
            end
        for (int x = 0; x < n; x++)
            for (int y = 0; y < n; y++)
                a[x][y] = longint'(mat[x * n + y]);
        det = det_n(a, n);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                cof = 0;
                if (det != 0) begin
                    int mr;
                    mr = 0;
                    // adj[r][c] = (-1)^(r+c) * minor(row c, col r)
                    for (int x = 0; x < n; x++)
                        if (x != c) begin
                            int mc;
                            mc = 0;
                            for (int y = 0; y < n; y++)
                                if (y != r) begin
                                    mnr[mr][mc] = a[x][y];
                                    mc++;
                                end
                            mr++;
                        end
                    cof = det_n(mnr, n - 1);
                    if ((r + c) % 2 == 1) cof = -cof;
                end
                e.data = cof[31:0];
                e.last = (r == n - 1) && (c == n - 1);
                e.det  = det[31:0];
                e.sing = (det == 0);
                exp_q[d].push_back(e);
            end
    endtask

    task automatic load_matrix(input int d, input int n);
        int guard;
        @(negedge clk);
        for (int e = 0; e < n * n; e++) begin
            in_data[d]  = mat[e];
            in_valid[d] = 1'b1;
            guard = 0;
            while (!in_ready[d] && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) check("load_in_ready_timeout", guard, 0);
            @(negedge clk);
        end
        in_valid[d] = 1'b0;
        in_data[d]  = '0;
    endtask

    task automatic drain(input int d, input bit toggle);
        int guard;
        guard = 0;
        while (exp_q[d].size() != 0 && guard < 3000) begin
            @(posedge clk);
            #1;
            if (toggle) out_ready[d] = ~out_ready[d];
            guard++;
        end
        check($sformatf("drain_timeout_d%0d", d), exp_q[d].size(), 0);
        out_ready[d] = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_identity(input int n);
        for (int x = 0; x < n * n; x++) mat[x] = (x % (n + 1) == 0) ? 1 : 0;
    endtask

    // Single compare process for all instances.
    always @(negedge clk) begin : cmp
        exp_t e;
        for (int d = 0; d < NI; d++) begin
            if (!rst && out_valid[d]) begin
                if (exp_q[d].size() == 0) begin
                    check($sformatf("d%0d_unexpected_beat", d), 1, 0);
                end else begin
                    e = exp_q[d][0];
                    check($sformatf("d%0d_out_data", d), longint'($signed(out_data[d])),
                          longint'($signed(e.data)));
                    check($sformatf("d%0d_det_o", d), longint'($signed(det_o[d])),
                          longint'($signed(e.det)));
                    check($sformatf("d%0d_out_last", d), out_last[d], e.last);
                    check($sformatf("d%0d_singular", d), singular[d], e.sing);
                    check($sformatf("d%0d_in_ready_in_out", d), in_ready[d], 0);
                    if (out_ready[d]) void'(exp_q[d].pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int guard;
        rst = 1'b1;
        for (int d = 0; d < NI; d++) begin
            in_valid[d]  = 1'b0;
            in_data[d]   = '0;
            out_ready[d] = 1'b1;
        end
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_in_ready",  in_ready[2],  1);
        check("rst_busy",      busy[2],      0);
        check("rst_out_valid", out_valid[2], 0);
        check("rst_out_last",  out_last[2],  0);
        check("rst_out_data",  out_data[2],  0);
        check("rst_det_o",     det_o[2],     0);
        check("rst_singular",  singular[2],  0);
        rst = 1'b0;
        @(negedge clk);

        // N=5 identity: det 1, adj = I, compute latency N*(1+(N-1)(2N+1)) = 225
        set_identity(5);
        build_expect(2, 5);
        check("pin_id5_det", longint'($signed(exp_q[2][0].det)), 1);
        check("pin_id5_last_beat", exp_q[2][24].last, 1);
        load_matrix(2, 5);
        cyc = 0; guard = 0;
        while (!out_valid[2] && guard < 2000) begin
            if (busy[2]) cyc++;
            @(negedge clk);
            guard++;
        end
        check("n5_compute_cycles", cyc, 225);
        drain(2, 1'b0);

        // N=2 [[4,7],[2,6]] -> det 10, out [6,-7,-2,4]
        mat[0] = 4; mat[1] = 7; mat[2] = 2; mat[3] = 6;
        build_expect(0, 2);
        check("pin_a47_det", longint'($signed(exp_q[0][0].det)), 10);
        check("pin_a47_o0", longint'($signed(exp_q[0][0].data)), 6);
        check("pin_a47_o1", longint'($signed(exp_q[0][1].data)), -7);
        check("pin_a47_o2", longint'($signed(exp_q[0][2].data)), -2);
        check("pin_a47_o3", longint'($signed(exp_q[0][3].data)), 4);
        load_matrix(0, 2);
        drain(0, 1'b0);

        // N=2 swap case -> det -1, out [0,-1,-1,0]
        mat[0] = 0; mat[1] = 1; mat[2] = 1; mat[3] = 0;
        build_expect(0, 2);
        check("pin_swap_det", longint'($signed(exp_q[0][0].det)), -1);
        check("pin_swap_o1", longint'($signed(exp_q[0][1].data)), -1);
        load_matrix(0, 2);
        drain(0, 1'b0);

        // N=3 singular -> singular=1, det 0, 9 zero beats
        mat[0] = 1; mat[1] = 2; mat[2] = 3;
        mat[3] = 2; mat[4] = 4; mat[5] = 6;
        mat[6] = 1; mat[7] = 0; mat[8] = 1;
        build_expect(1, 3);
        check("pin_sing_flag", exp_q[1][0].sing, 1);
        load_matrix(1, 3);
        drain(1, 1'b0);

        // N=3 general nonsingular with a swap in the middle step
        mat[0] = 2; mat[1] = -1; mat[2] = 0;
        mat[3] = 4; mat[4] = -2; mat[5] = 1;
        mat[6] = 1; mat[7] = 3;  mat[8] = -5;
        build_expect(1, 3);
        load_matrix(1, 3);
        drain(1, 1'b0);

        // N=2 [[4,7],[2,6]] under alternating backpressure
        mat[0] = 4; mat[1] = 7; mat[2] = 2; mat[3] = 6;
        build_expect(0, 2);
        load_matrix(0, 2);
        drain(0, 1'b1);

        // Reset during elimination of an N=5 load discards the work
        set_identity(5);
        load_matrix(2, 5);
        repeat (20) @(negedge clk);
        check("mid_busy_before_rst", busy[2], 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready",  in_ready[2],  1);
        check("mid_rst_busy",      busy[2],      0);
        check("mid_rst_out_valid", out_valid[2], 0);
        rst = 1'b0;
        @(negedge clk);
        build_expect(2, 5);
        load_matrix(2, 5);
        drain(2, 1'b0);

        // N=5 general nonsingular matrix
        mat[0]  = 2; mat[1]  = 1; mat[2]  = 0; mat[3]  = 0; mat[4]  = 1;
        mat[5]  = 0; mat[6]  = 3; mat[7]  = 1; mat[8]  = 0; mat[9]  = 0;
        mat[10] = 1; mat[11] = 0; mat[12] = 2; mat[13] = 1; mat[14] = 0;
        mat[15] = 0; mat[16] = 1; mat[17] = 0; mat[18] = 4; mat[19] = 1;
        mat[20] = 1; mat[21] = 0; mat[22] = 1; mat[23] = 0; mat[24] = 3;
        build_expect(2, 5);
        load_matrix(2, 5);
        drain(2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
